sobel_edge_scanner: RTL and testbench

- Initiator/consumer for the greyscale frame buffer's 3x3 neighbourhood port.
- Walks a window centre over the interior of the stored region and drives the frame buffer's edge coordinate inputs. Collects the eight neighbours returned with the edge-valid pulse, computes the Sobel gradient magnitude, thresholds it and streams one edge result per interior pixel downstream.
- Sits between the frame buffer and the edge-overlay/VGA-side writer.

---
 rtl/sobel_edge_scanner_if.sv | 28 ++
 rtl/sobel_edge_scanner.sv | 164 ++++++++++++++++
 tb/tb_sobel_edge_scanner.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/sobel_edge_scanner_if.sv
// Result stream from the Sobel edge scanner to the edge-overlay writer.
// The master side drives a result with valid; the slave side answers with ready.
interface sobel_edge_scanner_if;
   logic       edgeOutValid;
   logic       edgeOutReady;
   logic [9:0] edgeX;
   logic [8:0] edgeY;
   logic [6:0] edgeMag;
   logic [3:0] edgePixel;

   modport master (
      output edgeOutValid,
      output edgeX,
      output edgeY,
      output edgeMag,
      output edgePixel,
      input  edgeOutReady
   );

   modport slave (
      input  edgeOutValid,
      input  edgeX,
      input  edgeY,
      input  edgeMag,
      input  edgePixel,
      output edgeOutReady
   );
endinterface

// File: rtl/sobel_edge_scanner.sv
// Sobel edge scanner: walks a window centre over the interior of the stored
// region, requests each 3x3 neighbourhood from the frame buffer, waits for a
// settled (second matching) response, and streams |Gx|+|Gy| plus a
// thresholded edge pixel downstream with valid/ready backpressure.
module sobel_edge_scanner #(
   parameter int ROW_LENGTH     = 600,
   parameter int COL_LENGTH     = 400,
   parameter int COL_BIAS       = 20,
   parameter int ROW_BIAS       = 40,
   parameter int EDGE_THRESHOLD = 12
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   output logic [9:0] outX_edge,
   output logic [8:0] outY_edge,
   input  logic       edgeValid,
   input  logic [3:0] ul,
   input  logic [3:0] uc,
   input  logic [3:0] ur,
   input  logic [3:0] ml,
   input  logic [3:0] mr,
   input  logic [3:0] dl,
   input  logic [3:0] dc,
   input  logic [3:0] dr,
   input  logic [9:0] outX_edgeOut,
   input  logic [8:0] outY_edgeOut,
   sobel_edge_scanner_if.master edgeOut,
   output logic       busy,
   output logic       frameDone
);

   localparam int DATA_W = 4;
   localparam logic [9:0] X_FIRST = 10'(COL_BIAS + 1);
   localparam logic [9:0] X_LAST  = 10'(COL_BIAS + ROW_LENGTH - 2);
   localparam logic [8:0] Y_FIRST = 9'(ROW_BIAS + 1);
   localparam logic [8:0] Y_LAST  = 9'(ROW_BIAS + COL_LENGTH - 2);
   localparam logic [6:0] THRESH  = 7'(EDGE_THRESHOLD);

   typedef enum logic [1:0] {IDLE, WAIT, CALC, EMIT} state_t;

   state_t state;
   logic   matchCnt;

   logic [DATA_W-1:0] ulReg, ucReg, urReg, mlReg, mrReg, dlReg, dcReg, drReg;

   logic              echoMatch;
   logic              captureNbr;
   logic              lastPixel;
   logic signed [7:0] gx;
   logic signed [7:0] gy;
   logic [6:0]        mag;

   // Zero-extend a greyscale sample into the signed gradient domain.
   function automatic logic signed [7:0] widen(input logic [DATA_W-1:0] v);
      return $signed({{(8 - DATA_W){1'b0}}, v});
   endfunction

   // One Sobel column/row: a + 2b + c (max 60, fits the signed 8-bit range).
   function automatic logic signed [7:0] weighted(input logic [DATA_W-1:0] a,
                                                  input logic [DATA_W-1:0] b,
                                                  input logic [DATA_W-1:0] c);
      return widen(a) + (widen(b) <<< 1) + widen(c);
   endfunction

   // Absolute value of a gradient; |g| <= 60 so 7 bits always hold it.
   function automatic logic [6:0] absMag(input logic signed [7:0] g);
      return g[7] ? 7'(-g) : g[6:0];
   endfunction

   assign echoMatch  = (outX_edgeOut == outX_edge) && (outY_edgeOut == outY_edge);
   assign captureNbr = (state == WAIT) && edgeValid && echoMatch && matchCnt;
   assign lastPixel  = (outX_edge == X_LAST) && (outY_edge == Y_LAST);

   assign gx  = weighted(urReg, mrReg, drReg) - weighted(ulReg, mlReg, dlReg);
   assign gy  = weighted(dlReg, dcReg, drReg) - weighted(ulReg, ucReg, urReg);
   assign mag = absMag(gx) + absMag(gy);

   // Neighbourhood capture on the settled (second matching) response; data only, no reset.
   always_ff @(posedge clk) begin
      if (captureNbr) begin
         ulReg <= ul;
         ucReg <= uc;
         urReg <= ur;
         mlReg <= ml;
         mrReg <= mr;
         dlReg <= dl;
         dcReg <= dc;
         drReg <= dr;
      end
   end

   // Scan FSM: coordinate walk, echo matching, result register and handshake.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state                <= IDLE;
         matchCnt             <= 1'b0;
         outX_edge            <= X_FIRST;
         outY_edge            <= Y_FIRST;
         busy                 <= 1'b0;
         frameDone            <= 1'b0;
         edgeOut.edgeOutValid <= 1'b0;
         edgeOut.edgeX        <= '0;
         edgeOut.edgeY        <= '0;
         edgeOut.edgeMag      <= '0;
         edgeOut.edgePixel    <= '0;
      end else begin
         frameDone <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  outX_edge <= X_FIRST;
                  outY_edge <= Y_FIRST;
                  matchCnt  <= 1'b0;
                  busy      <= 1'b1;
                  state     <= WAIT;
               end
            end
            WAIT: begin
               // The first matching pulse after a coordinate change may mix
               // old and new neighbours, so only the second one is used.
               if (edgeValid && echoMatch) begin
                  if (matchCnt) begin
                     state <= CALC;
                  end else begin
                     matchCnt <= 1'b1;
                  end
               end
            end
            CALC: begin
               edgeOut.edgeX        <= outX_edge;
               edgeOut.edgeY        <= outY_edge;
               edgeOut.edgeMag      <= mag;
               edgeOut.edgePixel    <= (mag >= THRESH) ? 4'hF : 4'h0;
               edgeOut.edgeOutValid <= 1'b1;
               state                <= EMIT;
            end
            EMIT: begin
               if (edgeOut.edgeOutReady) begin
                  edgeOut.edgeOutValid <= 1'b0;
                  matchCnt             <= 1'b0;
                  if (lastPixel) begin
                     frameDone <= 1'b1;
                     busy      <= 1'b0;
                     outX_edge <= X_FIRST;
                     outY_edge <= Y_FIRST;
                     state     <= IDLE;
                  end else begin
                     if (outX_edge == X_LAST) begin
                        outX_edge <= X_FIRST;
                        outY_edge <= outY_edge + 9'd1;
                     end else begin
                        outX_edge <= outX_edge + 10'd1;
                     end
                     state <= WAIT;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sobel_edge_scanner.sv
// Directed bench for sobel_edge_scanner on a 5x4 region with zero biases
// (interior centres x=1..3, y=1..2) and threshold 12.
module tb_sobel_edge_scanner;
   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       start = 1'b0;
   logic       edgeValid = 1'b0;
   logic [3:0] ul = '0, uc = '0, ur = '0, ml = '0, mr = '0, dl = '0, dc = '0, dr = '0;
   logic [9:0] outX_edge;
   logic [8:0] outY_edge;
   logic [9:0] outX_edgeOut = '0;
   logic [8:0] outY_edgeOut = '0;
   logic       busy;
   logic       frameDone;

   int checks = 0;
   int errors = 0;

   // Neighbour packing: {ul,uc,ur,ml,mr,dl,dc,dr}
   localparam logic [31:0] FLAT  = 32'h7777_7777; // mag 0
   localparam logic [31:0] STEP  = 32'h08F0_F08F; // Gx=60, Gy=0 -> mag 60
   localparam logic [31:0] MAG10 = 32'h1202_0000; // Gx=-5, Gy=-5 -> mag 10
   localparam logic [31:0] MAG12 = 32'h0000_2031; // Gx=5, Gy=7 -> mag 12
   localparam logic [31:0] JUNK  = 32'h0F0F_0F0F;

   sobel_edge_scanner_if eo ();

   sobel_edge_scanner #(
      .ROW_LENGTH(5), .COL_LENGTH(4), .COL_BIAS(0), .ROW_BIAS(0), .EDGE_THRESHOLD(12)
   ) dut (
      .clk(clk), .reset(reset), .start(start),
      .outX_edge(outX_edge), .outY_edge(outY_edge),
      .edgeValid(edgeValid),
      .ul(ul), .uc(uc), .ur(ur), .ml(ml), .mr(mr), .dl(dl), .dc(dc), .dr(dr),
      .outX_edgeOut(outX_edgeOut), .outY_edgeOut(outY_edgeOut),
      .edgeOut(eo.master),
      .busy(busy), .frameDone(frameDone)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic setNbr(input logic [31:0] v);
      {ul, uc, ur, ml, mr, dl, dc, dr} = v;
   endtask

   // One frame-buffer response pulse with the given echo and neighbours.
   task automatic pulse(input int x, input int y, input logic [31:0] v);
      repeat (2) @(negedge clk);
      outX_edgeOut = 10'(x);
      outY_edgeOut = 9'(y);
      setNbr(v);
      edgeValid = 1'b1;
      @(negedge clk);
      edgeValid = 1'b0;
      setNbr(JUNK);
   endtask

   task automatic waitValid();
      int n = 0;
      while (eo.edgeOutValid !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("validTimeout", 32'(eo.edgeOutValid), 32'd1);
   endtask

   task automatic checkResult(input int x, input int y, input int m, input int p);
      check($sformatf("edgeX(%0d,%0d)", x, y), 32'(eo.edgeX), 32'(x));
      check($sformatf("edgeY(%0d,%0d)", x, y), 32'(eo.edgeY), 32'(y));
      check($sformatf("edgeMag(%0d,%0d)", x, y), 32'(eo.edgeMag), 32'(m));
      check($sformatf("edgePixel(%0d,%0d)", x, y), 32'(eo.edgePixel), 32'(p));
   endtask

   // Request check, two matching pulses, then the produced result.
   task automatic serve(input int x, input int y, input logic [31:0] v1,
                        input logic [31:0] v2, input int m, input int p);
      check($sformatf("reqX(%0d,%0d)", x, y), 32'(outX_edge), 32'(x));
      check($sformatf("reqY(%0d,%0d)", x, y), 32'(outY_edge), 32'(y));
      pulse(x, y, v1);
      pulse(x, y, v2);
      waitValid();
      checkResult(x, y, m, p);
   endtask

   task automatic accept();
      eo.edgeOutReady = 1'b1;
      @(negedge clk);
      eo.edgeOutReady = 1'b0;
      check("validDrop", 32'(eo.edgeOutValid), 32'd0);
   endtask

   initial begin
      eo.edgeOutReady = 1'b0;

      // Reset state
      #1 reset = 1'b0;
      #1;
      check("rstValid", 32'(eo.edgeOutValid), 32'd0);
      check("rstEdgeX", 32'(eo.edgeX), 32'd0);
      check("rstEdgeY", 32'(eo.edgeY), 32'd0);
      check("rstMag", 32'(eo.edgeMag), 32'd0);
      check("rstPixel", 32'(eo.edgePixel), 32'd0);
      check("rstBusy", 32'(busy), 32'd0);
      check("rstDone", 32'(frameDone), 32'd0);
      check("rstOutX", 32'(outX_edge), 32'd1);
      check("rstOutY", 32'(outY_edge), 32'd1);
      repeat (2) @(negedge clk);
      reset = 1'b1;

      // Frame 1: flat image, six results, frameDone after the last
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("busyAfterStart", 32'(busy), 32'd1);
      for (int y = 1; y <= 2; y++) begin
         for (int x = 1; x <= 3; x++) begin
            serve(x, y, FLAT, FLAT, 0, 0);
            accept();
            check($sformatf("frameDone(%0d,%0d)", x, y), 32'(frameDone),
                  (x == 3 && y == 2) ? 32'd1 : 32'd0);
         end
      end
      check("f1BusyEnd", 32'(busy), 32'd0);
      check("f1ReloadX", 32'(outX_edge), 32'd1);
      check("f1ReloadY", 32'(outY_edge), 32'd1);
      @(negedge clk);
      check("f1DonePulse", 32'(frameDone), 32'd0);

      // Frame 2: gradients, threshold, echo filter, backpressure
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      serve(1, 1, STEP, STEP, 60, 15);
      accept();
      serve(2, 1, MAG10, MAG10, 10, 0);
      accept();
      serve(3, 1, MAG12, MAG12, 12, 15);
      accept();

      // Stale echo ignored, first match discarded, second match used
      check("echoReqX", 32'(outX_edge), 32'd1);
      check("echoReqY", 32'(outY_edge), 32'd2);
      pulse(3, 1, STEP);
      pulse(1, 2, STEP);
      pulse(1, 2, FLAT);
      waitValid();
      checkResult(1, 2, 0, 0);
      accept();
      repeat (3) @(negedge clk);
      check("singleResult", 32'(eo.edgeOutValid), 32'd0);

      // Backpressure hold for 20 cycles
      serve(2, 2, STEP, STEP, 60, 15);
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         check($sformatf("bpValid%0d", i), 32'(eo.edgeOutValid), 32'd1);
      end
      checkResult(2, 2, 60, 15);
      check("bpOutX", 32'(outX_edge), 32'd2);
      check("bpOutY", 32'(outY_edge), 32'd2);
      accept();
      check("bpAdvX", 32'(outX_edge), 32'd3);
      check("bpAdvY", 32'(outY_edge), 32'd2);

      // Last result accepted together with a start pulse
      serve(3, 2, FLAT, FLAT, 0, 0);
      eo.edgeOutReady = 1'b1;
      start = 1'b1;
      @(negedge clk);
      eo.edgeOutReady = 1'b0;
      start = 1'b0;
      check("lastValidDrop", 32'(eo.edgeOutValid), 32'd0);
      check("lastDone", 32'(frameDone), 32'd1);
      check("lastBusy", 32'(busy), 32'd0);
      @(negedge clk);
      check("startIgnoredBusy", 32'(busy), 32'd0);
      check("lastDonePulse", 32'(frameDone), 32'd0);

      // Frame 3: start while busy, then reset during WAIT at (2,1)
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      serve(1, 1, FLAT, FLAT, 0, 0);
      accept();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("busyStartX", 32'(outX_edge), 32'd2);
      check("busyStartY", 32'(outY_edge), 32'd1);
      check("busyStartBusy", 32'(busy), 32'd1);
      pulse(2, 1, STEP);
      #2 reset = 1'b0;
      #1;
      check("midRstBusy", 32'(busy), 32'd0);
      check("midRstValid", 32'(eo.edgeOutValid), 32'd0);
      check("midRstEdgeX", 32'(eo.edgeX), 32'd0);
      check("midRstEdgeY", 32'(eo.edgeY), 32'd0);
      check("midRstMag", 32'(eo.edgeMag), 32'd0);
      check("midRstPixel", 32'(eo.edgePixel), 32'd0);
      check("midRstDone", 32'(frameDone), 32'd0);
      check("midRstOutX", 32'(outX_edge), 32'd1);
      check("midRstOutY", 32'(outY_edge), 32'd1);
      @(negedge clk);
      check("midRstNoDone", 32'(frameDone), 32'd0);
      reset = 1'b1;
      @(negedge clk);

      // Fresh start rescans from (1,1); second pulse supplies the result
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("freshBusy", 32'(busy), 32'd1);
      serve(1, 1, STEP, MAG12, 12, 15);
      accept();
      check("freshAdvX", 32'(outX_edge), 32'd2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
